// File: rtl/mem_pkg.sv
// Shared constants and the pipeline stage type for the fill-responder memory model.
package mem_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_DATA_W  = 16;
  localparam int MEM_LATENCY = 4;

  // One slot of the read-return pipeline.
  typedef struct packed {
    logic                  valid;
    logic [MEM_DATA_W-1:0] data;
  } mem_stage_t;

endpackage

// File: rtl/mem_delay_pipe.sv
// LATENCY-deep shift register of {valid, data} read returns.
// While hold=1 every stage keeps its contents, so each entry's remaining delay
// is preserved. Reset is asynchronous active-low and empties all stages.
module mem_delay_pipe
  import mem_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hold,
  input  mem_stage_t in_stage,
  output mem_stage_t out_stage
);

  // chain[0] is the entry being captured; chain[k] is the output of stage k.
  mem_stage_t chain [LATENCY+1];

  assign chain[0] = in_stage;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      mem_stage_t stage_q;
      mem_stage_t stage_d;

      // Shift from the previous stage unless the pipe is frozen.
      always_comb begin
        stage_d = chain[gi];
        if (hold) begin
          stage_d = stage_q;
        end
      end

      // Stage register; reset discards any in-flight read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign chain[gi+1] = stage_q;
    end
  endgenerate

  assign out_stage = chain[LATENCY];

endmodule

// File: rtl/mem_fill_responder.sv
// Word-addressed, fully pipelined main-memory model answering cache-fill requests.
// One read or write per cycle; read data returns with a one-cycle data_valid
// pulse LATENCY cycles after the request. Array contents survive reset.
// Optional build macro MEM_FILL_RESP_STALL_EN adds a stall input (freezes the
// return pipeline and ignores requests) and a busy output mirroring it.
module mem_fill_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int DEPTH   = 32768,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MEM_FILL_RESP_STALL_EN
  input  logic              stall,
  output logic              busy,
`endif
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_array [DEPTH];
  logic [ADDR_W-2:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic              hold;
  logic              wr_en;
  logic              rd_en;
  mem_stage_t        stage_in;
  mem_stage_t        stage_out;

  // Byte address bit 0 selects nothing: odd and even bytes share a word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr[0];

`ifdef MEM_FILL_RESP_STALL_EN
  assign hold = stall;
  assign busy = stall;
`else
  assign hold = 1'b0;
`endif

  // Request decode and combinational array read feeding pipeline stage 1.
  always_comb begin
    word_addr = addr[ADDR_W-1:1];
    idx       = IDX_W'(32'(word_addr) % 32'(DEPTH));
    wr_en     = enable & wr & ~hold;
    rd_en     = enable & ~wr & ~hold;
    stage_in  = '0;
    stage_in.valid = rd_en;
    if (rd_en) begin
      stage_in.data = MEM_DATA_W'(mem_array[idx]);
    end
  end

  // Array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[idx] <= data_in;
    end
  end

  mem_delay_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .in_stage  (stage_in),
    .out_stage (stage_out)
  );

  // Output strobe is suppressed while frozen; data is zero whenever not valid.
  always_comb begin
    data_valid = stage_out.valid & ~hold;
    data_out   = '0;
    if (data_valid) begin
      data_out = DATA_W'(stage_out.data);
    end
  end

endmodule
